// File: rtl/db_sched_pkg.sv
// db_sched_pkg: shared types and widths for the double-buffer bank scheduler.
//   db_state_e : scheduler FSM encoding
//   DB_ADDR_W  : default write-counter / depth width
//   DB_ITER_W  : default read-counter / iter_cnt width
package db_sched_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    STREAM  = 2'd1,
    WR_FULL = 2'd2,
    SWITCH  = 2'd3
  } db_state_e;

  localparam int DB_ADDR_W = 16;
  localparam int DB_ITER_W = 32;

endpackage

// File: rtl/db_term_counter.sv
// db_term_counter: up-counter that flags the increment reaching limit-1 and
// wraps to zero on that increment.
//   clk, reset : clock, async active-low reset
//   clr        : synchronous clear
//   inc        : count one event this cycle
//   limit      : number of events per wrap
//   count      : events counted since last wrap
//   last       : inc & (count == limit-1)
module db_term_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = inc & (count == (limit - W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       count <= '0;
    else if (clr)     count <= '0;
    else if (last)    count <= '0;
    else if (inc)     count <= count + W'(1);
  end

endmodule

// File: rtl/db_bank_scheduler.sv
// db_bank_scheduler: ping-pong bank scheduler for double-buffer mode.
// Gates producer/consumer requests into per-bank write/read strobes, counts
// depth writes and iter_cnt reads, and pulses switch_db to swap banks.
//   clk, reset          : clock, async active-low reset
//   clk_en, flush       : global enable, synchronous clear
//   depth, iter_cnt     : writes per fill, reads per drain (quasi-static)
//   wen_req, ren_req    : producer / consumer requests
//   wen_out, ren_out    : write / read grants to the core
//   switch_db           : bank-swap pulse (high while in SWITCH)
//   wr_bank             : bank being written; read bank is its complement
//   wr_count, rd_count  : accepted writes / reads in the current banks
//   cfg_err             : depth or iter_cnt is zero
//
// state   | meaning
// FILL    | write bank filling, read bank empty
// STREAM  | write bank filling, read bank valid
// WR_FULL | write bank complete, read bank still draining
// SWITCH  | swap cycle, no grants
module db_bank_scheduler
  import db_sched_pkg::*;
#(
  parameter int ADDR_W = DB_ADDR_W,
  parameter int ITER_W = DB_ITER_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] depth,
  input  logic [ITER_W-1:0] iter_cnt,
  input  logic              wen_req,
  input  logic              ren_req,
  output logic              wen_out,
  output logic              ren_out,
  output logic              switch_db,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_count,
  output logic [ITER_W-1:0] rd_count,
  output logic              cfg_err
);

  db_state_e state, state_nxt;
  logic      advance;
  logic      wr_last, rd_last;

  assign cfg_err = (depth == '0) | (iter_cnt == '0);
  assign advance = clk_en & ~cfg_err;

  // Grants also drop while reset is held, since FILL would otherwise
  // let a write through during reset.
  assign wen_out = wen_req & advance & reset & ((state == FILL) | (state == STREAM));
  assign ren_out = ren_req & advance & reset & ((state == STREAM) | (state == WR_FULL));

  // State is registered, so the pulse is registered and persists while
  // clk_en is low in SWITCH.
  assign switch_db = (state == SWITCH);

  db_term_counter #(.W(ADDR_W)) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (wen_out),
    .limit (depth),
    .count (wr_count),
    .last  (wr_last)
  );

  db_term_counter #(.W(ITER_W)) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (ren_out),
    .limit (iter_cnt),
    .count (rd_count),
    .last  (rd_last)
  );

  always_comb begin
    state_nxt = state;
    if (advance) begin
      unique case (state)
        FILL:    if (wr_last) state_nxt = SWITCH;
        STREAM: begin
          if (wr_last && rd_last) state_nxt = SWITCH;
          else if (wr_last)       state_nxt = WR_FULL;
          else if (rd_last)       state_nxt = FILL;
        end
        WR_FULL: if (rd_last) state_nxt = SWITCH;
        SWITCH:  state_nxt = STREAM;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FILL;
      wr_bank <= 1'b0;
    end else if (flush) begin
      state   <= FILL;
      wr_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (advance && state == SWITCH) wr_bank <= ~wr_bank;
    end
  end

endmodule

// File: tb/tb_db_bank_scheduler.sv
module tb_db_bank_scheduler;
  import db_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clk_en, flush, wen_req, ren_req;
  logic [15:0] depth;
  logic [31:0] iter_cnt;
  logic        wen_out, ren_out, switch_db, wr_bank, cfg_err;
  logic [15:0] wr_count;
  logic [31:0] rd_count;

  db_bank_scheduler dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .depth(depth), .iter_cnt(iter_cnt), .wen_req(wen_req), .ren_req(ren_req),
    .wen_out(wen_out), .ren_out(ren_out), .switch_db(switch_db),
    .wr_bank(wr_bank), .wr_count(wr_count), .rd_count(rd_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wen, ren, sw, bank, cfg;
    logic [15:0] wc;
    logic [31:0] rc;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  db_state_e   m_state;
  logic        m_bank;
  logic [15:0] m_wc;
  logic [31:0] m_rc;
  logic        last_sw, last_ren, last_wen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_state = FILL; m_bank = 1'b0; m_wc = '0; m_rc = '0;
  endtask

  // One cycle: drive inputs, push expectation, compare at negedge, advance model.
  task automatic step(input logic rst, input logic en, input logic fl,
                      input logic wr, input logic rd);
    exp_t e;
    logic cfg, ok, wl, rl;
    reset = rst; clk_en = en; flush = fl; wen_req = wr; ren_req = rd;
    if (!rst) model_clear();
    cfg = (depth == 16'd0) || (iter_cnt == 32'd0);
    ok  = rst && en && !cfg;
    e.wen  = wr && ok && (m_state == FILL || m_state == STREAM);
    e.ren  = rd && ok && (m_state == STREAM || m_state == WR_FULL);
    e.sw   = (m_state == SWITCH);
    e.bank = m_bank;
    e.cfg  = cfg;
    e.wc   = m_wc;
    e.rc   = m_rc;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk("grants",   {62'd0, wen_out, ren_out}, {62'd0, e.wen, e.ren});
    chk("switch",   64'(switch_db), 64'(e.sw));
    chk("wr_bank",  64'(wr_bank),   64'(e.bank));
    chk("cfg_err",  64'(cfg_err),   64'(e.cfg));
    chk("wr_count", 64'(wr_count),  64'(e.wc));
    chk("rd_count", 64'(rd_count),  64'(e.rc));
    last_sw = switch_db; last_ren = ren_out; last_wen = wen_out;
    wl = e.wen && (m_wc == depth - 16'd1);
    rl = e.ren && (m_rc == iter_cnt - 32'd1);
    if (rst) begin
      if (fl) model_clear();
      else begin
        if (e.wen) m_wc = wl ? 16'd0 : m_wc + 16'd1;
        if (e.ren) m_rc = rl ? 32'd0 : m_rc + 32'd1;
        if (ok) begin
          case (m_state)
            FILL:    if (wl) m_state = SWITCH;
            STREAM:  if (wl && rl) m_state = SWITCH;
                     else if (wl) m_state = WR_FULL;
                     else if (rl) m_state = FILL;
            WR_FULL: if (rl) m_state = SWITCH;
            SWITCH:  begin m_state = STREAM; m_bank = ~m_bank; end
            default: m_state = FILL;
          endcase
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n, n2;
    logic seen_full, seen_block, done;
    reset = 1'b0; clk_en = 1'b1; flush = 1'b0; wen_req = 1'b0; ren_req = 1'b0;
    depth = 16'd4; iter_cnt = 32'd4;
    model_clear();

    // 1: reset then fill first bank
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    n = 0;
    for (int i = 0; i < 4; i++) begin step(1, 1, 0, 1, 0); n += int'(last_wen); end
    chk("t1_grants", 64'(n), 64'd4);
    step(1, 1, 0, 1, 0);
    chk("t1_switch", 64'(last_sw), 64'd1);
    chk("t1_bank", 64'(wr_bank), 64'd1);
    chk("t1_state", 64'(dut.state), 64'(STREAM));

    // 3: slow consumer stalls in WR_FULL
    seen_full = 0; seen_block = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1, 1, 0, 1, (i % 3) == 2);
      if (last_sw) done = 1;
      if (dut.state == WR_FULL) seen_full = 1;
      if (dut.state == WR_FULL && !last_sw) begin
        step(1, 1, 0, 1, 0);
        if (!last_wen) seen_block = 1;
        i++;
        if (last_sw) done = 1;
      end
    end
    chk("t3_wr_full", 64'(seen_full), 64'd1);
    chk("t3_wen_blocked", 64'(seen_block), 64'd1);
    chk("t3_switch_seen", 64'(done), 64'd1);

    // 4: clk_en low while in SWITCH
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
    chk("t4_in_switch", 64'(dut.state), 64'(SWITCH));
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1);
      chk("t4_hold_sw", 64'(switch_db), 64'd1);
      chk("t4_hold_bank", 64'(wr_bank), 64'd0);
    end
    step(1, 1, 0, 0, 0);
    chk("t4_toggle", 64'(wr_bank), 64'd1);
    chk("t4_sw_done", 64'(switch_db), 64'd0);

    // 5: flush mid-fill in STREAM
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    chk("t5_wc_pre", 64'(wr_count), 64'd2);
    step(1, 1, 1, 0, 0);
    chk("t5_state", 64'(dut.state), 64'(FILL));
    chk("t5_counts", {16'd0, wr_count, rd_count}, 64'd0);
    chk("t5_bank", 64'(wr_bank), 64'd0);
    step(1, 1, 0, 0, 1);
    chk("t5_ren", 64'(last_ren), 64'd0);

    // 2: steady stream, depth = iter_cnt = 9
    depth = 16'd9; iter_cnt = 32'd9;
    step(1, 1, 1, 0, 0);
    n = 0; n2 = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 1, 1);
      n += int'(last_sw);
      if (!last_wen) n2++;
    end
    chk("t2_switches", 64'(n), 64'd4);
    chk("t2_bubbles", 64'(n2), 64'd4);

    // 6: depth = 0
    depth = 16'd0;
    step(1, 1, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 1, 1);
      n += int'(last_wen) + int'(last_ren);
    end
    chk("t6_no_grants", 64'(n), 64'd0);
    chk("t6_cfg_err", 64'(cfg_err), 64'd1);

    // random traffic, depth 3 / iter 5
    depth = 16'd3; iter_cnt = 32'd5;
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(i != 150, $urandom_range(0, 5) != 0, $urandom_range(0, 60) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
